// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS32 core: stall vector, flush and exception redirect.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [4:0]  EXC_NONE   = 5'h10,
   parameter logic [4:0]  EXC_ERET   = 5'h11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallreq_id,
   input  logic        stallreq_exe,
   input  logic        div_start,
   input  logic [4:0]  mem_exccode,
   input  logic [31:0] epc_i,
   output logic [3:0]  stall,
   output logic        flush,
   output logic [31:0] exc_pc,
   output logic        div_busy,
   output logic        div_done
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] DIV  = 1'b1;

   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   logic [0:0] state;
   logic [7:0] cnt;
   logic       exc;
   logic       cnt_zero;
   logic       div_hold;

   assign exc      = (mem_exccode != EXC_NONE);
   assign cnt_zero = (cnt == 8'd0);

   // The div_start cycle itself counts as the first of DIV_CYCLES stall cycles.
   assign div_hold = ((state == IDLE) && div_start) || ((state == DIV) && !cnt_zero);

   assign flush    = exc;
   assign exc_pc   = (mem_exccode == EXC_ERET) ? epc_i : EXC_VECTOR;
   assign div_busy = (state == DIV);
   assign div_done = (state == DIV) && cnt_zero && !exc;

   always_comb begin
      stall = 4'b0000;
      if (exc)
         stall = 4'b0000;
      else if (stallreq_exe || div_hold)
         stall = 4'b1111;
      else if (stallreq_id)
         stall = 4'b0111;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!exc && div_start) begin
                  state <= DIV;
                  cnt   <= DIV_LOAD;
               end
            end
            DIV: begin
               if (exc) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else if (!cnt_zero) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cyc <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (stall != 4'b0000)
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         if (flush)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed plan items plus randomized traffic against a
// timestamp-based behavioural model of the divide window.
module tb_pipe_ctrl;

   localparam int DIVC = 32;

   logic        clk;
   logic        rst_n;
   logic        stallreq_id;
   logic        stallreq_exe;
   logic        div_start;
   logic [4:0]  mem_exccode;
   logic [31:0] epc_i;
   logic [3:0]  stall;
   logic        flush;
   logic [31:0] exc_pc;
   logic        div_busy;
   logic        div_done;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cyc;
   logic [31:0] perf_flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Model: the cycle index a divide was accepted (-1 when none is running)
   int          cyc = 0;
   int          divAt = -1;
   logic [31:0] mStallCnt = 0;
   logic [31:0] mFlushCnt = 0;

   logic [3:0]  sStall;
   logic        sFlush;
   logic [31:0] sExcPc;
   logic        sBusy;
   logic        sDone;

   pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stallreq_id(stallreq_id),
      .stallreq_exe(stallreq_exe),
      .div_start(div_start),
      .mem_exccode(mem_exccode),
      .epc_i(epc_i),
      .stall(stall),
      .flush(flush),
      .exc_pc(exc_pc),
      .div_busy(div_busy),
      .div_done(div_done)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cyc(perf_stall_cyc),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic id, input logic exe, input logic ds,
                                input logic [4:0] code, input logic [31:0] epc);
      stallreq_id  = id;
      stallreq_exe = exe;
      div_start    = ds;
      mem_exccode  = code;
      epc_i        = epc;
   endtask

   function automatic bit inDiv();
      return (divAt >= 0) && (cyc > divAt) && (cyc <= divAt + DIVC);
   endfunction

   task automatic expected(output logic [3:0] es, output logic ef, output logic [31:0] ep,
                           output logic eb, output logic ed);
      bit exc;
      bit divStall;
      exc      = (mem_exccode != 5'h10);
      divStall = (!inDiv() && div_start) || (inDiv() && cyc < divAt + DIVC);
      ef = exc;
      ep = (mem_exccode == 5'h11) ? epc_i : 32'hBFC00380;
      if (exc)                           es = 4'b0000;
      else if (stallreq_exe || divStall) es = 4'b1111;
      else if (stallreq_id)              es = 4'b0111;
      else                               es = 4'b0000;
      eb = inDiv();
      ed = inDiv() && (cyc == divAt + DIVC) && !exc;
   endtask

   task automatic compareModel();
      logic [3:0]  es;
      logic        ef, eb, ed;
      logic [31:0] ep;
      expected(es, ef, ep, eb, ed);
      sStall = stall;
      sFlush = flush;
      sExcPc = exc_pc;
      sBusy  = div_busy;
      sDone  = div_done;
      checkOutput("stall", {28'd0, stall}, {28'd0, es});
      checkOutput("flush", {31'd0, flush}, {31'd0, ef});
      checkOutput("exc_pc", exc_pc, ep);
      checkOutput("div_busy", {31'd0, div_busy}, {31'd0, eb});
      checkOutput("div_done", {31'd0, div_done}, {31'd0, ed});
`ifdef PIPE_CTRL_PERF_EN
      checkOutput("perf_stall_cyc", perf_stall_cyc, mStallCnt);
      checkOutput("perf_flush_cnt", perf_flush_cnt, mFlushCnt);
`endif
   endtask

   task automatic modelUpdate();
      logic [3:0]  es;
      logic        ef, eb, ed;
      logic [31:0] ep;
      expected(es, ef, ep, eb, ed);
      if (es != 4'b0000) mStallCnt = mStallCnt + 32'd1;
      if (ef)            mFlushCnt = mFlushCnt + 32'd1;
      if (ef)
         divAt = -1;
      else if (!inDiv() && div_start)
         divAt = cyc;
      else if (inDiv() && cyc == divAt + DIVC)
         divAt = -1;
      cyc++;
   endtask

   task automatic modelReset();
      divAt     = -1;
      mStallCnt = 0;
      mFlushCnt = 0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
   task automatic stepCycle();
      #3;
      compareModel();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   initial begin
      int stallCycles, busyCycles, doneCycle, firstBusy;

      applyStimulus(0, 0, 0, 5'h10, 32'h0);
      rst_n = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_stall", {28'd0, stall}, 32'd0);
      checkOutput("reset_busy", {31'd0, div_busy}, 32'd0);
      checkOutput("reset_exc_pc", exc_pc, 32'hBFC00380);
      rst_n = 1'b1;

      // Plan 1: idle after reset
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         checkOutput("idle_stall", {28'd0, sStall}, 32'd0);
         checkOutput("idle_flush", {31'd0, sFlush}, 32'd0);
      end

      // Plan 2: single load-use pulse
      applyStimulus(1, 0, 0, 5'h10, 32'h0);
      stepCycle();
      checkOutput("loaduse_stall", {28'd0, sStall}, 32'h7);
      applyStimulus(0, 0, 0, 5'h10, 32'h0);
      stepCycle();
      checkOutput("loaduse_release", {28'd0, sStall}, 32'h0);

      // Plan 3: full divide
      stallCycles = 0; busyCycles = 0; doneCycle = 0; firstBusy = 0;
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(0, 0, (i == 1), 5'h10, 32'h0);
         stepCycle();
         if (sStall == 4'hF) stallCycles++;
         if (sBusy) begin
            busyCycles++;
            if (firstBusy == 0) firstBusy = i;
         end
         if (sDone && doneCycle == 0) doneCycle = i;
         if (i == 33) checkOutput("div_release_stall", {28'd0, sStall}, 32'h0);
      end
      checkOutput("div_stall_cycles", stallCycles, 32'd32);
      checkOutput("div_busy_cycles", busyCycles, 32'd32);
      checkOutput("div_busy_first", firstBusy, 32'd2);
      checkOutput("div_done_cycle", doneCycle, 32'd33);

      // Plan 4: exception in the 10th divide cycle
      doneCycle = 0;
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(0, 0, (i == 1), (i == 10) ? 5'h08 : 5'h10, 32'h0);
         stepCycle();
         if (sDone) doneCycle = i;
         if (i == 10) begin
            checkOutput("exc_flush", {31'd0, sFlush}, 32'd1);
            checkOutput("exc_stall", {28'd0, sStall}, 32'd0);
            checkOutput("exc_vector", sExcPc, 32'hBFC00380);
         end
         if (i == 11) checkOutput("exc_abort_busy", {31'd0, sBusy}, 32'd0);
      end
      checkOutput("exc_no_done", doneCycle, 32'd0);

      // Plan 5: ERET beats both stall requests
      applyStimulus(1, 1, 0, 5'h11, 32'h8000_1234);
      stepCycle();
      checkOutput("eret_flush", {31'd0, sFlush}, 32'd1);
      checkOutput("eret_pc", sExcPc, 32'h8000_1234);
      checkOutput("eret_stall", {28'd0, sStall}, 32'd0);
      applyStimulus(0, 0, 0, 5'h10, 32'h0);
      stepCycle();

      // Plan 6: asynchronous reset while cnt=5 (cycle 28 of the divide)
      for (int i = 1; i <= 27; i++) begin
         applyStimulus(0, 0, (i == 1), 5'h10, 32'h0);
         stepCycle();
      end
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst_stall", {28'd0, stall}, 32'd0);
      checkOutput("async_rst_busy", {31'd0, div_busy}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      checkOutput("async_rst_perf_stall", perf_stall_cyc, 32'd0);
      checkOutput("async_rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      doneCycle = 0; busyCycles = 0;
      for (int i = 1; i <= 10; i++) begin
         stepCycle();
         if (sDone) doneCycle = i;
         if (sBusy) busyCycles++;
      end
      checkOutput("async_rst_no_done", doneCycle, 32'd0);
      checkOutput("async_rst_no_busy", busyCycles, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] code;
         code = 5'h10;
         if ($urandom_range(0, 19) == 0)      code = 5'($urandom);
         else if ($urandom_range(0, 39) == 0) code = 5'h11;
         applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 7) == 0), code, $urandom);
         stepCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
